// File: rtl/fpu_wb_stage.sv
// fpu_wb_stage
//   Writeback stage behind the FPU execution unit.
//   - FPR results are written to the FP register file one cycle after completion.
//   - GPR-bound results (compares, fclass, fmv.x, fcvt.w) are queued in order
//     until the shared integer writeback port accepts them.
//   - fflags and the invalid-op indication accumulate stickily for the CSR unit.
//
// Optional feature macro: FPU_WB_BYPASS_EN
//   When defined, a GPR result that completes while the queue is empty and the
//   integer port is ready goes out combinationally in the same cycle and is not
//   queued. When undefined, every GPR result goes through the queue.
//
// Parameters
//   FPLEN  FP datapath width
//   DEPTH  GPR result queue entries (power of 2, >= 2)
//
// Ports
//   clk, rst_l          clock, asynchronous active-low reset
//   fpu_complete        FPU op finished this cycle
//   fpu_complete_rd     finished op targets a GPR
//   fpu_result_1        FPR result
//   fpu_result_rd       GPR result
//   wb_rd_addr          destination register, valid with fpu_complete
//   sflags/IV_exception status of the op that completed the previous cycle
//   gpr_wb_ready        integer writeback port accepts gpr_wr_* this cycle
//   csr_fflags_we/wd    CSR write of fflags
//   iv_clear            clears iv_pending
//   fpr_wr_*            FP register file write port
//   gpr_wr_*            integer writeback request (held until gpr_wb_ready)
//   fflags, iv_pending  sticky status
//   fpu_stall           issue must hold further FPU ops
//   q_overflow          sticky error: push into a full queue
module fpu_wb_stage #(
   parameter int FPLEN = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             fpu_complete,
   input  logic             fpu_complete_rd,
   input  logic [FPLEN-1:0] fpu_result_1,
   input  logic [31:0]      fpu_result_rd,
   input  logic [4:0]       wb_rd_addr,
   input  logic [4:0]       sflags,
   input  logic             IV_exception,
   input  logic             gpr_wb_ready,
   input  logic             csr_fflags_we,
   input  logic [4:0]       csr_fflags_wd,
   input  logic             iv_clear,
   output logic             fpr_wr_en,
   output logic [4:0]       fpr_wr_addr,
   output logic [FPLEN-1:0] fpr_wr_data,
   output logic             gpr_wr_en,
   output logic [4:0]       gpr_wr_addr,
   output logic [31:0]      gpr_wr_data,
   output logic [4:0]       fflags,
   output logic             iv_pending,
   output logic             fpu_stall,
   output logic             q_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } gpr_ent_t;

   // ---------------------------------------------------------------- FPR path
   logic             fpr_en_q;
   logic [4:0]       fpr_addr_q;
   logic [FPLEN-1:0] fpr_data_q;
   logic             fpr_fire;

   assign fpr_fire = fpu_complete & ~fpu_complete_rd;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         fpr_en_q   <= 1'b0;
         fpr_addr_q <= '0;
         fpr_data_q <= '0;
      end else begin
         fpr_en_q <= fpr_fire;
         if (fpr_fire) begin
            fpr_addr_q <= wb_rd_addr;
            fpr_data_q <= fpu_result_1;
         end
      end
   end

   assign fpr_wr_en   = fpr_en_q;
   assign fpr_wr_addr = fpr_addr_q;
   assign fpr_wr_data = fpr_data_q;

   // ---------------------------------------------------------------- GPR queue
   gpr_ent_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            gpr_req, byp, push, push_ok, pop, q_empty, q_full;
   gpr_ent_t        head;

   // x0 writes are architecturally dropped, so they never occupy a slot.
   assign gpr_req = fpu_complete & fpu_complete_rd & (wb_rd_addr != 5'd0);
   assign q_empty = (count_q == '0);
   assign q_full  = (count_q == CW'(DEPTH));

`ifdef FPU_WB_BYPASS_EN
   assign byp = q_empty & gpr_req & gpr_wb_ready;
`else
   assign byp = 1'b0;
`endif

   assign push    = gpr_req & ~byp;
   assign pop     = ~q_empty & gpr_wb_ready;
   // A pop frees the head slot this edge, so push at full is legal with a pop.
   assign push_ok = push & (~q_full | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push & q_full & ~pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         if (push_ok) mem_q[wr_ptr_q] <= '{addr: wb_rd_addr, data: fpu_result_rd};
      end
   end

   assign head        = mem_q[rd_ptr_q];
   assign gpr_wr_en   = ~q_empty | byp;
   assign gpr_wr_addr = byp ? wb_rd_addr    : head.addr;
   assign gpr_wr_data = byp ? fpu_result_rd : head.data;
   // Leaves room for the one op that may already be in flight when stall rises.
   assign fpu_stall   = (count_q >= CW'(DEPTH - 1));
   assign q_overflow  = ovf_q;

   // ---------------------------------------------------------------- flags
   // sflags/IV_exception arrive one cycle after completion; flag_pending marks
   // that cycle.
   logic       flag_pend_q;
   logic [4:0] fflags_q, fflags_d;
   logic       ivp_q, ivp_d;
   logic [4:0] new_flags;

   assign new_flags = flag_pend_q ? sflags : 5'd0;

   always_comb begin
      fflags_d = fflags_q | new_flags;
      // CSR write lands first; flags of the op retiring this cycle go on top.
      if (csr_fflags_we) fflags_d = csr_fflags_wd | new_flags;
      // Set wins over a simultaneous clear.
      ivp_d = (ivp_q & ~iv_clear) | (flag_pend_q & IV_exception);
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         flag_pend_q <= 1'b0;
         fflags_q    <= '0;
         ivp_q       <= 1'b0;
      end else begin
         flag_pend_q <= fpu_complete;
         fflags_q    <= fflags_d;
         ivp_q       <= ivp_d;
      end
   end

   assign fflags     = fflags_q;
   assign iv_pending = ivp_q;

endmodule

// File: tb/tb_fpu_wb_stage.sv
module tb_fpu_wb_stage;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        fpu_complete, fpu_complete_rd;
   logic [15:0] fpu_result_1;
   logic [31:0] fpu_result_rd;
   logic [4:0]  wb_rd_addr, sflags, csr_fflags_wd;
   logic        IV_exception, gpr_wb_ready, csr_fflags_we, iv_clear;
   logic        fpr_wr_en, gpr_wr_en, iv_pending, fpu_stall, q_overflow;
   logic [4:0]  fpr_wr_addr, gpr_wr_addr, fflags;
   logic [15:0] fpr_wr_data;
   logic [31:0] gpr_wr_data;

   int n_chk  = 0;
   int n_pass = 0;

   fpu_wb_stage #(.FPLEN(16), .DEPTH(4)) dut (
      .clk(clk), .rst_l(rst_l),
      .fpu_complete(fpu_complete), .fpu_complete_rd(fpu_complete_rd),
      .fpu_result_1(fpu_result_1), .fpu_result_rd(fpu_result_rd),
      .wb_rd_addr(wb_rd_addr), .sflags(sflags), .IV_exception(IV_exception),
      .gpr_wb_ready(gpr_wb_ready), .csr_fflags_we(csr_fflags_we),
      .csr_fflags_wd(csr_fflags_wd), .iv_clear(iv_clear),
      .fpr_wr_en(fpr_wr_en), .fpr_wr_addr(fpr_wr_addr), .fpr_wr_data(fpr_wr_data),
      .gpr_wr_en(gpr_wr_en), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data),
      .fflags(fflags), .iv_pending(iv_pending), .fpu_stall(fpu_stall),
      .q_overflow(q_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        c, crd;
      logic [4:0]  a;
      logic [15:0] r1;
      logic [31:0] rrd;
      logic [4:0]  sf;
      logic        iv, rdy, cwe;
      logic [4:0]  cwd;
      logic        ivc;
      logic        fen;
      logic [4:0]  fa;
      logic [15:0] fd;
      logic        gen;
      logic [4:0]  ga;
      logic [31:0] gd;
      logic [4:0]  ff;
      logic        ivp, st, ov;
   } vec_t;

   function automatic vec_t v(string n,
      logic c, logic crd, logic [4:0] a, logic [15:0] r1, logic [31:0] rrd,
      logic [4:0] sf, logic iv, logic rdy, logic cwe, logic [4:0] cwd, logic ivc,
      logic fen, logic [4:0] fa, logic [15:0] fd,
      logic gen, logic [4:0] ga, logic [31:0] gd,
      logic [4:0] ff, logic ivp, logic st, logic ov);
      vec_t t;
      t.name = n; t.c = c; t.crd = crd; t.a = a; t.r1 = r1; t.rrd = rrd;
      t.sf = sf; t.iv = iv; t.rdy = rdy; t.cwe = cwe; t.cwd = cwd; t.ivc = ivc;
      t.fen = fen; t.fa = fa; t.fd = fd; t.gen = gen; t.ga = ga; t.gd = gd;
      t.ff = ff; t.ivp = ivp; t.st = st; t.ov = ov;
      return t;
   endfunction

   task automatic drive(logic c, logic crd, logic [4:0] a, logic [15:0] r1,
      logic [31:0] rrd, logic [4:0] sf, logic iv, logic rdy, logic cwe,
      logic [4:0] cwd, logic ivc);
      fpu_complete = c; fpu_complete_rd = crd; wb_rd_addr = a;
      fpu_result_1 = r1; fpu_result_rd = rrd; sflags = sf; IV_exception = iv;
      gpr_wb_ready = rdy; csr_fflags_we = cwe; csr_fflags_wd = cwd; iv_clear = ivc;
   endtask

   // Addresses/data are only compared while their write strobe is expected high.
   task automatic check(string name, logic fen, logic [4:0] fa, logic [15:0] fd,
      logic gen, logic [4:0] ga, logic [31:0] gd, logic [4:0] ff,
      logic ivp, logic st, logic ov);
      logic [67:0] act, exp;
      act = {fpr_wr_en, fen ? fpr_wr_addr : 5'd0, fen ? fpr_wr_data : 16'd0,
             gpr_wr_en, gen ? gpr_wr_addr : 5'd0, gen ? gpr_wr_data : 32'd0,
             fflags, iv_pending, fpu_stall, q_overflow};
      exp = {fen, fen ? fa : 5'd0, fen ? fd : 16'd0,
             gen, gen ? ga : 5'd0, gen ? gd : 32'd0, ff, ivp, st, ov};
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   vec_t tbl[$];

   initial begin
      //                    c  crd a      r1        rrd           sf       iv rdy we wd ivc  fen fa  fd        gen ga  gd            ff       ivp st ov
      tbl.push_back(v("fpr_write",   1,0,5'd5, 16'h3C00,32'h0,     5'b00000,0,0,0,5'd0,0, 1,5'd5,16'h3C00, 0,5'd0,32'h0,     5'b00000,0,0,0));
      tbl.push_back(v("fpr_once_nx", 0,0,5'd0, 16'h0,   32'h0,     5'b00001,0,0,0,5'd0,0, 0,5'd0,16'h0,    0,5'd0,32'h0,     5'b00001,0,0,0));
      tbl.push_back(v("push_x1",     1,1,5'd1, 16'h0,   32'd1,     5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd1,32'd1,     5'b00001,0,0,0));
      tbl.push_back(v("push_x2_nv",  1,1,5'd2, 16'h0,   32'd0,     5'b10000,1,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd1,32'd1,     5'b10001,1,0,0));
      tbl.push_back(v("push_x3",     1,1,5'd3, 16'h0,   32'd1,     5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd1,32'd1,     5'b10001,1,1,0));
      tbl.push_back(v("drain_x1",    0,0,5'd0, 16'h0,   32'h0,     5'b00000,0,1,0,5'd0,0, 0,5'd0,16'h0,    1,5'd2,32'd0,     5'b10001,1,0,0));
      tbl.push_back(v("drain_x2",    0,0,5'd0, 16'h0,   32'h0,     5'b00000,0,1,0,5'd0,0, 0,5'd0,16'h0,    1,5'd3,32'd1,     5'b10001,1,0,0));
      tbl.push_back(v("drain_x3",    0,0,5'd0, 16'h0,   32'h0,     5'b00000,0,1,0,5'd0,0, 0,5'd0,16'h0,    0,5'd0,32'h0,     5'b10001,1,0,0));
      tbl.push_back(v("x0_discard",  1,1,5'd0, 16'h0,   32'hFFFF,  5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    0,5'd0,32'h0,     5'b10001,1,0,0));
      tbl.push_back(v("x0_idle",     0,0,5'd0, 16'h0,   32'h0,     5'b00001,0,0,0,5'd0,0, 0,5'd0,16'h0,    0,5'd0,32'h0,     5'b10001,1,0,0));
      tbl.push_back(v("fpr_f4",      1,0,5'd4, 16'h1234,32'h0,     5'b00000,0,0,0,5'd0,0, 1,5'd4,16'h1234, 0,5'd0,32'h0,     5'b10001,1,0,0));
      tbl.push_back(v("csr_wr_nx",   0,0,5'd0, 16'h0,   32'h0,     5'b00001,0,0,1,5'd0,0, 0,5'd0,16'h0,    0,5'd0,32'h0,     5'b00001,1,0,0));
      tbl.push_back(v("iv_clear",    0,0,5'd0, 16'h0,   32'h0,     5'b00000,0,0,0,5'd0,1, 0,5'd0,16'h0,    0,5'd0,32'h0,     5'b00001,0,0,0));
      tbl.push_back(v("fpr_f0",      1,0,5'd0, 16'hBEEF,32'h0,     5'b00000,0,0,0,5'd0,0, 1,5'd0,16'hBEEF, 0,5'd0,32'h0,     5'b00001,0,0,0));
      tbl.push_back(v("iv_set_wins", 0,0,5'd0, 16'h0,   32'h0,     5'b00000,1,0,0,5'd0,1, 0,5'd0,16'h0,    0,5'd0,32'h0,     5'b00001,1,0,0));
      tbl.push_back(v("csr_wr_only", 0,0,5'd0, 16'h0,   32'h0,     5'b00000,0,0,1,5'b01010,0, 0,5'd0,16'h0, 0,5'd0,32'h0,    5'b01010,1,0,0));
      tbl.push_back(v("fill_1",      1,1,5'd10,16'h0,   32'hA0,    5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd10,32'hA0,   5'b01010,1,0,0));
      tbl.push_back(v("fill_2",      1,1,5'd11,16'h0,   32'hA1,    5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd10,32'hA0,   5'b01010,1,0,0));
      tbl.push_back(v("fill_3",      1,1,5'd12,16'h0,   32'hA2,    5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd10,32'hA0,   5'b01010,1,1,0));
      tbl.push_back(v("fill_4",      1,1,5'd13,16'h0,   32'hA3,    5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd10,32'hA0,   5'b01010,1,1,0));
      tbl.push_back(v("overflow",    1,1,5'd14,16'h0,   32'hDEAD,  5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd10,32'hA0,   5'b01010,1,1,1));
      tbl.push_back(v("pop_a0",      0,0,5'd0, 16'h0,   32'h0,     5'b00000,0,1,0,5'd0,0, 0,5'd0,16'h0,    1,5'd11,32'hA1,   5'b01010,1,1,1));
      tbl.push_back(v("push_pop_3",  1,1,5'd15,16'h0,   32'hB0,    5'b00000,0,1,0,5'd0,0, 0,5'd0,16'h0,    1,5'd12,32'hA2,   5'b01010,1,1,1));
      tbl.push_back(v("refill_4",    1,1,5'd16,16'h0,   32'hB1,    5'b00000,0,0,0,5'd0,0, 0,5'd0,16'h0,    1,5'd12,32'hA2,   5'b01010,1,1,1));
      tbl.push_back(v("push_pop_full",1,1,5'd17,16'h0,  32'hB2,    5'b00000,0,1,0,5'd0,0, 0,5'd0,16'h0,    1,5'd13,32'hA3,   5'b01010,1,1,1));
      tbl.push_back(v("drain_a3",    0,0,5'd0, 16'h0,   32'h0,     5'b00000,0,1,0,5'd0,0, 0,5'd0,16'h0,    1,5'd15,32'hB0,   5'b01010,1,1,1));

      // Reset state.
      rst_l = 1'b0;
      drive(0,0,5'd0,16'h0,32'h0,5'd0,0,0,0,5'd0,0);
      #1 check("reset_state", 0,5'd0,16'h0, 0,5'd0,32'h0, 5'd0,0,0,0);
      @(negedge clk); @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      check("post_reset", 0,5'd0,16'h0, 0,5'd0,32'h0, 5'd0,0,0,0);

      // Table: inputs applied at a negedge, outputs sampled at the next negedge.
      foreach (tbl[i]) begin
         drive(tbl[i].c, tbl[i].crd, tbl[i].a, tbl[i].r1, tbl[i].rrd, tbl[i].sf,
               tbl[i].iv, tbl[i].rdy, tbl[i].cwe, tbl[i].cwd, tbl[i].ivc);
         @(negedge clk);
         check(tbl[i].name, tbl[i].fen, tbl[i].fa, tbl[i].fd, tbl[i].gen,
               tbl[i].ga, tbl[i].gd, tbl[i].ff, tbl[i].ivp, tbl[i].st, tbl[i].ov);
      end

      // Asynchronous reset mid-drain: outputs clear without a clock edge.
      #2 rst_l = 1'b0;
      #1 check("async_reset", 0,5'd0,16'h0, 0,5'd0,32'h0, 5'd0,0,0,0);
      @(negedge clk);
      rst_l = 1'b1;
      drive(0,0,5'd0,16'h0,32'h0,5'd0,0,1,0,5'd0,0);
      @(negedge clk);
      check("reset_discards_q", 0,5'd0,16'h0, 0,5'd0,32'h0, 5'd0,0,0,0);

      // GPR result to an empty queue with the port ready.
      drive(1,1,5'd7,16'h0,32'd2,5'd0,0,1,0,5'd0,0);
      #1;
`ifdef FPU_WB_BYPASS_EN
      check("bypass_same_cycle", 0,5'd0,16'h0, 1,5'd7,32'd2, 5'd0,0,0,0);
`else
      check("no_bypass_same_cycle", 0,5'd0,16'h0, 0,5'd0,32'h0, 5'd0,0,0,0);
`endif
      @(posedge clk); #1;
      drive(0,0,5'd0,16'h0,32'h0,5'd0,0,1,0,5'd0,0);
      #1;
`ifdef FPU_WB_BYPASS_EN
      check("bypass_not_queued", 0,5'd0,16'h0, 0,5'd0,32'h0, 5'd0,0,0,0);
`else
      check("queued_latency1", 0,5'd0,16'h0, 1,5'd7,32'd2, 5'd0,0,0,0);
`endif
      @(posedge clk); #1;
      check("after_write_empty", 0,5'd0,16'h0, 0,5'd0,32'h0, 5'd0,0,0,0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
